ram_latency_model: RTL and testbench

//  Word-addressed data RAM with a fixed, programmable access latency, downstream of the

---
 rtl/ram_latency_model.sv | 125 ++++++++++++
 tb/tb_ram_latency_model.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_latency_model.sv
// ram_latency_model
//   Word-addressed 32-bit data RAM with a fixed, programmable access latency.
//   Sits downstream of the memory/coherence controller. Each request waits
//   LAT BUSY cycles and then gets one ACCESS cycle. This shapes the
//   controller's two-word RAM phases and its dwait timing.
//
// Parameters
//   LAT    BUSY cycles before ACCESS (0..15); 0 gives ACCESS in the first cycle
//   DEPTH  number of 32-bit words, power of two
//
// Ports
//   CLK       in   1   clock, rising edge
//   nRST      in   1   asynchronous active-low reset
//   ramREN    in   1   read request, level, held until ACCESS
//   ramWEN    in   1   write request, level, held until ACCESS
//   ramaddr   in   32  byte address; word index = ramaddr[IDX_W+1:2]
//   ramstore  in   32  write data, sampled in the ACCESS cycle
//   ramload   out  32  read data, non-zero only in a read ACCESS cycle
//   ramstate  out  2   FREE=0 BUSY=1 ACCESS=2 ERROR=3
module ram_latency_model #(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT_C = 4'(LAT);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  logic [3:0]       r_cnt;
  logic [IDX_W-1:0] r_reqAddr;
  logic             r_reqWen;
  logic             r_valid;
  logic [31:0]      r_mem [DEPTH];

  logic [IDX_W-1:0] w_idx;
  logic             w_new;
  logic [3:0]       w_cntEff;
  ramstate_t        w_state;
  logic [3:0]       w_cntNext;
  logic [IDX_W-1:0] w_addrNext;
  logic             w_wenNext;
  logic             w_validNext;
  logic             w_memWe;
  logic             w_unusedAddrBits;

  // The upper address bits alias onto the same word. The byte-lane bits are
  // ignored. No range error is raised.
  assign w_idx            = ramaddr[IDX_W+1:2];
  assign w_unusedAddrBits = ^{ramaddr[31:IDX_W+2], ramaddr[1:0]};

  // A request differs from the one being counted when its address or its
  // direction changes. It then starts counting from zero in this same cycle.
  assign w_new    = !r_valid || (w_idx != r_reqAddr) || (ramWEN != r_reqWen);
  assign w_cntEff = w_new ? 4'd0 : r_cnt;

  // State decode and next-state. The counter is only carried across a BUSY
  // cycle. FREE, ERROR and ACCESS all leave the tracker empty, so a request
  // held past its ACCESS pays the full latency again.
  always_comb begin
    w_state     = FREE;
    w_cntNext   = 4'd0;
    w_validNext = 1'b0;
    w_addrNext  = r_reqAddr;
    w_wenNext   = r_reqWen;
    w_memWe     = 1'b0;
    if (ramREN && ramWEN) begin
      w_state = ERROR;
    end else if (ramREN || ramWEN) begin
      if (w_cntEff == LAT_C) begin
        w_state = ACCESS;
        w_memWe = ramWEN;
      end else begin
        w_state     = BUSY;
        w_cntNext   = 4'(w_cntEff + 4'd1);
        w_validNext = 1'b1;
        w_addrNext  = w_idx;
        w_wenNext   = ramWEN;
      end
    end
  end

  // Request tracker registers. Reset abandons any request in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt     <= 4'd0;
      r_reqAddr <= '0;
      r_reqWen  <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_cnt     <= w_cntNext;
      r_reqAddr <= w_addrNext;
      r_reqWen  <= w_wenNext;
      r_valid   <= w_validNext;
    end
  end

  // Storage array. It has no reset. A write is committed only at the end of
  // its ACCESS cycle, and never while reset is asserted.
  always_ff @(posedge CLK) begin
    if (w_memWe && nRST) begin
      r_mem[w_idx] <= ramstore;
    end
  end

  // The read is combinational. A read ACCESS in the cycle after a write
  // ACCESS to the same word therefore already sees the new data.
  assign ramload  = (w_state == ACCESS && ramREN) ? r_mem[w_idx] : 32'h0;
  assign ramstate = w_state;

endmodule

// File: tb/tb_ram_latency_model.sv
// tb_ram_latency_model
//   Self-checking bench for ram_latency_model. One instance uses LAT=2 and is
//   driven by directed scenarios and then by random traffic. It is checked
//   against a behavioural model: a per-word memory plus a count of how many
//   consecutive cycles the identical request has been held. A second instance
//   uses LAT=0 and covers zero latency and address aliasing.
module tb_ram_latency_model;

  localparam int         LAT   = 2;
  localparam int         DEPTH = 1024;
  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  logic        zRen, zWen;
  logic [31:0] zAddr, zStore, zLoad;
  logic [1:0]  zState;

  int checks = 0;
  int errors = 0;

  // Behavioural model for the LAT=2 instance
  logic [31:0] mdlMem [int];
  bit          holdValid;
  bit          holdWen;
  int          holdIdx;
  int          holdLen;

  ram_latency_model #(.LAT(LAT), .DEPTH(DEPTH)) u_dut (
    .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  ram_latency_model #(.LAT(0), .DEPTH(DEPTH)) u_lat0 (
    .CLK(CLK), .nRST(nRST), .ramREN(zRen), .ramWEN(zWen),
    .ramaddr(zAddr), .ramstore(zStore), .ramload(zLoad), .ramstate(zState)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request cycle on the LAT=2 instance and checks it against the
  // model. The model then advances at the clock edge.
  task automatic applyStimulus(input string tag, input bit ren, input bit wen,
                               input logic [31:0] addr, input logic [31:0] data);
    logic [1:0]  expState;
    logic [31:0] expLoad;
    int          idx;
    int          len;
    @(negedge CLK);
    ramREN = ren; ramWEN = wen; ramaddr = addr; ramstore = data;
    #1;
    idx = int'((addr >> 2) % DEPTH);
    len = 0;
    if (!ren && !wen) expState = S_FREE;
    else if (ren && wen) expState = S_ERROR;
    else begin
      len = (holdValid && holdWen == wen && holdIdx == idx) ? holdLen + 1 : 1;
      expState = (len == LAT + 1) ? S_ACCESS : S_BUSY;
    end
    checkOutput({tag, ".state"}, {30'd0, ramstate}, {30'd0, expState});
    if (expState == S_ACCESS && ren) begin
      if (mdlMem.exists(idx)) checkOutput({tag, ".load"}, ramload, mdlMem[idx]);
    end else begin
      checkOutput({tag, ".load"}, ramload, 32'h0);
    end
    @(posedge CLK);
    if (expState == S_BUSY) begin
      holdValid = 1'b1; holdWen = wen; holdIdx = idx; holdLen = len;
    end else begin
      holdValid = 1'b0; holdLen = 0;
    end
    if (expState == S_ACCESS && wen) mdlMem[idx] = data;
  endtask

  // Holds one request for a number of cycles
  task automatic holdRequest(input string tag, input bit ren, input bit wen,
                             input logic [31:0] addr, input logic [31:0] data, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(tag, ren, wen, addr, data);
  endtask

  task automatic applyReset(input string tag);
    @(negedge CLK);
    nRST = 1'b0; ramREN = 1'b0; ramWEN = 1'b0;
    #1;
    checkOutput({tag, ".state"}, {30'd0, ramstate}, {30'd0, S_FREE});
    checkOutput({tag, ".load"}, ramload, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    holdValid = 1'b0; holdLen = 0;
  endtask

  task automatic checkLat0(input string tag, input logic [1:0] expState, input logic [31:0] expLoad);
    #1;
    checkOutput({tag, ".state"}, {30'd0, zState}, {30'd0, expState});
    checkOutput({tag, ".load"}, zLoad, expLoad);
  endtask

  initial begin
    logic [31:0] rAddr, rData;
    bit          rRen, rWen;
    int          op;
    nRST = 1'b0;
    ramREN = 1'b0; ramWEN = 1'b0; ramaddr = '0; ramstore = '0;
    zRen = 1'b0; zWen = 1'b0; zAddr = '0; zStore = '0;
    holdValid = 1'b0; holdWen = 1'b0; holdIdx = 0; holdLen = 0;
    #2;
    checkOutput("reset.state", {30'd0, ramstate}, {30'd0, S_FREE});
    checkOutput("reset.load", ramload, 32'h0);
    checkOutput("reset.lat0state", {30'd0, zState}, {30'd0, S_FREE});
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // Write then read back with latency
    holdRequest("t1.wr", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 3);
    holdRequest("t1.rd", 1'b1, 1'b0, 32'h40, 32'h0, 3);
    checkOutput("t1.mdl", mdlMem[16], 32'hDEADBEEF);

    // Controller two-word pattern, address changes on the ACCESS edge
    holdRequest("t2.wr0", 1'b0, 1'b1, 32'h80, 32'h11, 3);
    holdRequest("t2.wr1", 1'b0, 1'b1, 32'h84, 32'h22, 3);
    holdRequest("t2.rd0", 1'b1, 1'b0, 32'h80, 32'h0, 3);
    holdRequest("t2.rd1", 1'b1, 1'b0, 32'h84, 32'h0, 3);

    // Held request after ACCESS pays the latency again
    holdRequest("t2b.hold", 1'b0, 1'b1, 32'h88, 32'h33, 6);

    // Address change mid-BUSY restarts the count
    holdRequest("t3.pre", 1'b0, 1'b1, 32'h104, 32'h104, 3);
    holdRequest("t3.pre2", 1'b0, 1'b1, 32'h200, 32'h5, 3);
    applyStimulus("t3.rdA", 1'b1, 1'b0, 32'h100, 32'h0);
    holdRequest("t3.rdB", 1'b1, 1'b0, 32'h104, 32'h0, 3);
    applyStimulus("t3.wrA", 1'b0, 1'b1, 32'h200, 32'hBAD);
    holdRequest("t3.wrB", 1'b0, 1'b1, 32'h204, 32'hC0DE, 3);
    holdRequest("t3.chk", 1'b1, 1'b0, 32'h200, 32'h0, 3);

    // Simultaneous read and write is an ERROR and commits nothing
    holdRequest("t4.pre", 1'b0, 1'b1, 32'h10, 32'h33, 3);
    holdRequest("t4.err", 1'b1, 1'b1, 32'h10, 32'h55, 3);
    holdRequest("t4.chk", 1'b1, 1'b0, 32'h10, 32'h0, 3);

    // Reset in the middle of a write drops it
    holdRequest("t5.pre", 1'b0, 1'b1, 32'h20, 32'h01, 3);
    applyStimulus("t5.wr", 1'b0, 1'b1, 32'h20, 32'hAA);
    applyReset("t5.rst");
    holdRequest("t5.chk", 1'b1, 1'b0, 32'h20, 32'h0, 3);

    // Zero latency and aliasing on the LAT=0 instance
    @(negedge CLK);
    zWen = 1'b1; zAddr = 32'h1000; zStore = 32'h7;
    checkLat0("t6.wr", S_ACCESS, 32'h0);
    @(negedge CLK);
    zWen = 1'b0; zRen = 1'b1; zAddr = 32'h0;
    checkLat0("t6.rd", S_ACCESS, 32'h7);
    @(negedge CLK);
    zRen = 1'b0; zWen = 1'b1; zAddr = 32'h2007; zStore = 32'h99;
    checkLat0("t6.wr2", S_ACCESS, 32'h0);
    @(negedge CLK);
    zWen = 1'b0; zRen = 1'b1; zAddr = 32'h4;
    checkLat0("t6.rd2", S_ACCESS, 32'h99);
    @(negedge CLK);
    zRen = 1'b0;
    checkLat0("t6.free", S_FREE, 32'h0);

    // Random traffic: requests held for random spans, with occasional changes
    rRen = 1'b0; rWen = 1'b0; rAddr = '0; rData = '0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 3 || n == 0) begin
        op = int'($urandom_range(0, 19));
        rRen = (op < 8) || (op == 19);
        rWen = (op >= 8 && op < 16) || (op == 19);
        rAddr = ({29'd0, 3'($urandom_range(0, 7))} << 2)
              | ({30'd0, 2'($urandom_range(0, 3))} << 12)
              | {30'd0, 2'($urandom_range(0, 3))};
        rData = $urandom;
      end
      applyStimulus("rand", rRen, rWen, rAddr, rData);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
